// File: rtl/sift_pkg.sv
// Shared types and constants for the gradient magnitude/orientation stage.
package sift_pkg;

    localparam int ORI_BINS = 8;
    localparam int BIN_W    = $clog2(ORI_BINS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/grad_octant.sv
// Combinational magnitude approximation and exact 45-degree orientation binning
// of one (gx, gy) gradient pair.
module grad_octant
    import sift_pkg::*;
#(
    parameter int BIT_DEPTH = 8
) (
    input  logic signed [BIT_DEPTH:0] gx,
    input  logic signed [BIT_DEPTH:0] gy,
    output logic        [BIT_DEPTH:0] mag,
    output logic        [BIN_W-1:0]   bin
);

    localparam logic [BIT_DEPTH:0] ONE = {{BIT_DEPTH{1'b0}}, 1'b1};

    logic [BIT_DEPTH:0]   ax;
    logic [BIT_DEPTH:0]   ay;
    logic [BIT_DEPTH:0]   mx;
    logic [BIT_DEPTH:0]   mn;
    logic [BIT_DEPTH:0]   half;
    logic [BIT_DEPTH+1:0] sum;
    logic                 gx_neg;
    logic                 gy_neg;
    logic                 gx_pos;
    logic                 gy_pos;
    logic                 ay_ge_ax;
    logic                 ax_ge_ay;

    // The unsigned BIT_DEPTH+1 bit result holds |-2^BIT_DEPTH| exactly.
    always_comb begin
        ax = gx[BIT_DEPTH] ? (~gx + ONE) : gx;
        ay = gy[BIT_DEPTH] ? (~gy + ONE) : gy;
    end

    always_comb begin
        ay_ge_ax = (ay >= ax);
        ax_ge_ay = (ax >= ay);
        mx       = ax_ge_ay ? ax : ay;
        mn       = ax_ge_ay ? ay : ax;
        half     = mn >> 1;
        sum      = {1'b0, mx} + {1'b0, half};
        mag      = sum[BIT_DEPTH+1] ? {(BIT_DEPTH+1){1'b1}} : sum[BIT_DEPTH:0];
    end

    always_comb begin
        gx_neg = gx[BIT_DEPTH];
        gy_neg = gy[BIT_DEPTH];
        gx_pos = !gx[BIT_DEPTH] && (gx != '0);
        gy_pos = !gy[BIT_DEPTH] && (gy != '0);
    end

    // Each quadrant is half-open so axis and diagonal angles land in the higher bin.
    always_comb begin
        bin = 3'd0;
        if (gx_pos && !gy_neg) begin
            bin = ay_ge_ax ? 3'd1 : 3'd0;
        end else if (!gx_pos && gy_pos) begin
            bin = ax_ge_ay ? 3'd3 : 3'd2;
        end else if (gx_neg && !gy_pos) begin
            bin = ay_ge_ax ? 3'd5 : 3'd4;
        end else if (!gx_neg && gy_neg) begin
            bin = ax_ge_ay ? 3'd7 : 3'd6;
        end
    end

endmodule

// File: rtl/grad_mag_orient.sv
// Full-frame pass over the gradient BRAMs producing per-pixel magnitude and
// orientation bin, written 3 cycles after each read address is issued.
module grad_mag_orient
    import sift_pkg::*;
#(
    parameter  int WIDTH     = 64,
    parameter  int HEIGHT    = 64,
    parameter  int BIT_DEPTH = 8,
    localparam int NPIX      = WIDTH * HEIGHT,
    localparam int AW        = $clog2(NPIX)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    output logic [AW-1:0]         grad_read_addr,
    output logic                  grad_read_valid,
    input  logic signed [BIT_DEPTH:0] gx_in,
    input  logic signed [BIT_DEPTH:0] gy_in,
    output logic [AW-1:0]         mag_write_addr,
    output logic                  mag_write_valid,
    output logic [BIT_DEPTH:0]    mag_out,
    output logic [AW-1:0]         ori_write_addr,
    output logic                  ori_write_valid,
    output logic [BIN_W-1:0]      ori_bin_out,
    output logic                  busy_out,
    output logic                  done_out,
    output state_t                fsm_state
);

    // Strobes are plain valids with no back-pressure: an address/data word is
    // meaningful exactly in the cycles its valid is high, and is never stalled.

    localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

    state_t                state;
    state_t                next_state;
    logic                  done_set;
    logic                  pipe_v1;
    logic                  pipe_v2;
    logic [AW-1:0]         pipe_a1;
    logic [AW-1:0]         pipe_a2;
    logic [BIT_DEPTH:0]    mag_c;
    logic [BIN_W-1:0]      bin_c;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        done_set   = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (grad_read_addr == LAST) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (mag_write_valid && (mag_write_addr == LAST)) begin
                    next_state = IDLE;
                    done_set   = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign fsm_state = state;
    assign busy_out  = (state != IDLE);

    // Address counter restarts at 0 whenever the next cycle is the first of RUN.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            grad_read_addr  <= '0;
            grad_read_valid <= 1'b0;
            done_out        <= 1'b0;
        end else begin
            grad_read_valid <= (next_state == RUN);
            grad_read_addr  <= ((state == RUN) && (next_state == RUN)) ?
                               grad_read_addr + AW'(1) : '0;
            done_out        <= done_set;
        end
    end

    // Two stages matching the BRAM read latency.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pipe_v1 <= 1'b0;
            pipe_v2 <= 1'b0;
            pipe_a1 <= '0;
            pipe_a2 <= '0;
        end else begin
            pipe_v1 <= grad_read_valid;
            pipe_v2 <= pipe_v1;
            pipe_a1 <= grad_read_addr;
            pipe_a2 <= pipe_a1;
        end
    end

    grad_octant #(
        .BIT_DEPTH (BIT_DEPTH)
    ) u_octant (
        .gx  (gx_in),
        .gy  (gy_in),
        .mag (mag_c),
        .bin (bin_c)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mag_write_valid <= 1'b0;
            ori_write_valid <= 1'b0;
            mag_write_addr  <= '0;
            ori_write_addr  <= '0;
            mag_out         <= '0;
            ori_bin_out     <= '0;
        end else begin
            mag_write_valid <= pipe_v2;
            ori_write_valid <= pipe_v2;
            if (pipe_v2) begin
                mag_write_addr <= pipe_a2;
                ori_write_addr <= pipe_a2;
                mag_out        <= mag_c;
                ori_bin_out    <= bin_c;
            end
        end
    end

endmodule

// File: doc/grad_mag_orient.md
GRAD_MAG_ORIENT -- requirements
Module: grad_mag_orient

Interface
REQ-001 Parameter WIDTH, default 64, image width in pixels.
REQ-002 Parameter HEIGHT, default 64, image height in pixels.
REQ-003 Parameter BIT_DEPTH, default 8, source pixel depth; gradients are BIT_DEPTH+1 bits signed.
REQ-004 clk_in  input  1  single clock; all logic on its rising edge.
REQ-005 rst_in  input  1  asynchronous, active-high reset.
REQ-006 start_in  input  1  one-cycle pulse that starts a full-frame pass.
REQ-007 grad_read_addr  output  $clog2(WIDTH*HEIGHT)  shared read address to the x-gradient and y-gradient BRAMs.
REQ-008 grad_read_valid  output  1  high on cycles that issue a read.
REQ-009 gx_in  input  BIT_DEPTH+1  signed x gradient, valid 2 cycles after its address.
REQ-010 gy_in  input  BIT_DEPTH+1  signed y gradient, valid 2 cycles after its address.
REQ-011 mag_write_addr  output  $clog2(WIDTH*HEIGHT)  magnitude BRAM write address.
REQ-012 mag_write_valid  output  1  magnitude write strobe.
REQ-013 mag_out  output  BIT_DEPTH+1  unsigned magnitude.
REQ-014 ori_write_addr  output  $clog2(WIDTH*HEIGHT)  orientation BRAM write address.
REQ-015 ori_write_valid  output  1  orientation write strobe.
REQ-016 ori_bin_out  output  3  orientation bin 0..7.
REQ-017 busy_out  output  1  high from the cycle after start is accepted until done.
REQ-018 done_out  output  1  one-cycle pulse after the last write.

Function
REQ-019 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start_in; RUN->DRAIN after address WIDTH*HEIGHT-1 is issued; DRAIN->IDLE after the last write.
REQ-020 RUN issues addresses 0..WIDTH*HEIGHT-1 in raster order, one per cycle, with grad_read_valid high and no gaps.
REQ-021 The valid strobe travels through a 2-stage pipe aligned to the BRAM latency; gx/gy are sampled when the pipe output is high.
REQ-022 Result for address A is written with both write strobes high exactly 3 cycles after A is issued, and mag_write_addr = ori_write_addr = A.
REQ-023 Magnitude = max(|gx|,|gy|) + (min(|gx|,|gy|) >> 1), computed in BIT_DEPTH+2 bits and saturated to 2^(BIT_DEPTH+1)-1.
REQ-024 Bin = floor((atan2(gy,gx) mod 360°)/45°), resolved exactly from signs and the |gx| vs |gy| comparison, with no trigonometry.
REQ-025 An angle exactly on a 45° boundary goes to the higher bin (mod 8); gx=gy=0 gives bin 0 and magnitude 0.
REQ-026 Absolute value of the most negative input (-2^BIT_DEPTH) is represented exactly, without wrap.
REQ-027 done_out pulses in the cycle after the final write; busy_out falls in the same cycle.
REQ-028 start_in is ignored while busy_out is high.
REQ-029 A frame takes WIDTH*HEIGHT+4 cycles from start_in to done_out.

Reset
REQ-030 rst_in asserted at any time, including mid-frame, forces IDLE immediately.
REQ-031 While rst_in is asserted, every strobe, busy_out, done_out, address and data output is 0, and the valid pipe is cleared.
REQ-032 After rst_in is released, no write occurs until a new start_in.

Structure
REQ-033 The state enum and the constant ORI_BINS=8 reside in shared package sift_pkg.
REQ-034 Magnitude and bin logic reside in a combinational sub-module grad_octant (gx, gy in; mag, bin out), instantiated once and registered at its output.

Verification
REQ-035 WIDTH=HEIGHT=4, gx=gy=0 everywhere -> 16 writes with mag 0, bin 0; done_out pulses at cycle 20 after start_in.
REQ-036 Single pixels (gx,gy) = (10,0),(10,10),(0,10),(-10,10),(-10,0),(-10,-10),(0,-10),(10,-10) -> bins 0..7; mags 10,15,10,15,10,15,10,15.
REQ-037 gx=-256, gy=-256 (BIT_DEPTH=8) -> mag 384, bin 5, no wrap.
REQ-038 Random gradient frame -> every write address equals its read address + 0 and arrives 3 cycles after its read, with results matching a reference model.
REQ-039 rst_in asserted at pixel 7 of 16 -> all outputs 0, no further writes; a fresh start_in then yields a full 16-write frame.
REQ-040 start_in pulsed again mid-frame -> ignored: exactly one done_out and 16 writes.
